// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register and its command sequencer.
package usr_pkg;

    localparam int USR_W  = 4;
    localparam int USR_CW = 3;

    localparam logic [1:0] SEL_HOLD = 2'd0;
    localparam logic [1:0] SEL_SHR  = 2'd1;
    localparam logic [1:0] SEL_SHL  = 2'd2;
    localparam logic [1:0] SEL_LOAD = 2'd3;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_SHR  = 2'd1,
        OP_SHL  = 2'd2,
        OP_ROTR = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/usr_seq_ctrl_if.sv
// Command channel into the sequencer. A command transfers in a cycle where
// cmd_valid and cmd_ready are both high; cmd_* fields are sampled only then.
interface usr_seq_ctrl_if #(
    parameter int W  = 4,
    parameter int CW = 3
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [CW-1:0] cmd_cnt;
    logic [W-1:0]  cmd_data;
    logic          cmd_sin;

    modport master (
        output cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_sin,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_sin,
        output cmd_ready
    );
endinterface

// File: rtl/universal_shift_reg.sv
// 4-mode universal shift register: hold, shift right, shift left, parallel load.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int W = USR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   sel,
    input  logic [W-1:0] p_din,
    input  logic         s_right_din,
    input  logic         s_left_din,
    output logic [W-1:0] p_dout
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_dout <= '0;
        end else begin
            case (sel)
                SEL_SHR:  p_dout <= {s_right_din, p_dout[W-1:1]};
                SEL_SHL:  p_dout <= {p_dout[W-2:0], s_left_din};
                SEL_LOAD: p_dout <= p_din;
                default:  p_dout <= p_dout;
            endcase
        end
    end
endmodule

// File: rtl/usr_seq_ctrl.sv
// Command sequencer for the USR: turns one load/shift/rotate command into a
// run of registered select cycles, then pulses done (or aborted).
module usr_seq_ctrl
    import usr_pkg::*;
#(
    parameter int W  = USR_W,
    parameter int CW = USR_CW
) (
    input  logic           clk,
    input  logic           rst,
    usr_seq_ctrl_if.slave  cmd,
    input  logic           abort,
    output logic [1:0]     usr_sel,
    output logic [W-1:0]   usr_p_din,
    output logic           usr_s_right_din,
    output logic           usr_s_left_din,
    input  logic [W-1:0]   usr_p_dout,
    output logic           busy,
    output logic           done,
    output logic           aborted,
    output state_t         dbg_state
);
    state_t        state_q, state_d;
    op_t           op_q, op_d, acc_op;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sin_q, sin_d;
    logic [W-1:0]  data_q, data_d;
    logic [1:0]    sel_q, sel_d;
    logic          abrt_q, abrt_d;
    logic          ready;
    logic          fb_unused;

    assign acc_op        = op_t'(cmd.cmd_op);
    assign ready         = (state_q == ST_IDLE) && !rst;
    assign cmd.cmd_ready = ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            cnt_q   <= '0;
            sin_q   <= 1'b0;
            data_q  <= '0;
            sel_q   <= SEL_HOLD;
            abrt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            sin_q   <= sin_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            abrt_q  <= abrt_d;
        end
    end

    // sel_d is the select the USR sees in the *next* cycle.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        sin_d   = sin_q;
        data_d  = data_q;
        sel_d   = SEL_HOLD;
        abrt_d  = abrt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid && ready) begin
                    op_d    = acc_op;
                    cnt_d   = cmd.cmd_cnt;
                    sin_d   = cmd.cmd_sin;
                    data_d  = cmd.cmd_data;
                    abrt_d  = 1'b0;
                    state_d = ST_RUN;
                    case (acc_op)
                        OP_LOAD: sel_d = SEL_LOAD;
                        OP_SHL:  sel_d = SEL_SHL;
                        default: sel_d = SEL_SHR;
                    endcase
                    // A zero-step shift/rotate has no active cycle at all.
                    if (acc_op != OP_LOAD && cmd.cmd_cnt == '0) begin
                        state_d = ST_DONE;
                        sel_d   = SEL_HOLD;
                    end
                end
            end
            ST_RUN: begin
                if (abort || op_q == OP_LOAD || cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                    abrt_d  = abort;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    sel_d = sel_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign usr_sel   = sel_q;
    assign usr_p_din = data_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE) && !abrt_q;
    assign aborted   = (state_q == ST_DONE) && abrt_q;
    assign dbg_state = state_q;

    // Rotate feeds the current LSB straight back into the MSB.
    assign usr_s_right_din = (op_q == OP_ROTR) ? usr_p_dout[0] :
                             (op_q == OP_SHR)  ? sin_q : 1'b0;
    assign usr_s_left_din  = (op_q == OP_SHL)  ? sin_q : 1'b0;
    assign fb_unused       = ^usr_p_dout[W-1:1];
endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Bench for usr_seq_ctrl driving a real universal_shift_reg; directed table,
// hand-written reset/abort sequences and random commands against a closed-form model.
module tb_usr_seq_ctrl;
    import usr_pkg::*;

    localparam int W  = 4;
    localparam int CW = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         abort;
    logic [1:0]   usr_sel;
    logic [W-1:0] usr_p_din;
    logic [W-1:0] usr_p_dout;
    logic         usr_s_right_din;
    logic         usr_s_left_din;
    logic         busy;
    logic         done;
    logic         aborted;
    state_t       dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    int model_q = 0;

    always #5 clk = ~clk;

    usr_seq_ctrl_if #(.W(W), .CW(CW)) cmd_if ();

    usr_seq_ctrl #(.W(W), .CW(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd             (cmd_if),
        .abort           (abort),
        .usr_sel         (usr_sel),
        .usr_p_din       (usr_p_din),
        .usr_s_right_din (usr_s_right_din),
        .usr_s_left_din  (usr_s_left_din),
        .usr_p_dout      (usr_p_dout),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .dbg_state       (dbg_state)
    );

    universal_shift_reg #(.W(W)) usr (
        .clk         (clk),
        .rst         (rst),
        .sel         (usr_sel),
        .p_din       (usr_p_din),
        .s_right_din (usr_s_right_din),
        .s_left_din  (usr_s_left_din),
        .p_dout      (usr_p_dout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, $signed(act), $signed(exp), $time);
        end
    endtask

    // Register value after n steps of op, from the arithmetic meaning of each op.
    function automatic int model(input int r, input int op, input int n, input int sin, input int data);
        int k;
        case (op)
            0: return data;
            1: begin
                if (n >= 4) return sin ? 15 : 0;
                return (r >> n) | (sin ? ((15 << (4 - n)) & 15) : 0);
            end
            2: begin
                if (n >= 4) return sin ? 15 : 0;
                return ((r << n) & 15) | (sin ? ((1 << n) - 1) : 0);
            end
            default: begin
                k = n % 4;
                return ((r >> k) | (r << (4 - k))) & 15;
            end
        endcase
    endfunction

    function automatic int steps_of(input int op, input int cnt, input int abort_step);
        int len;
        len = (op == 0) ? 1 : cnt;
        if (abort_step >= 1 && abort_step <= len) return abort_step;
        return len;
    endfunction

    function automatic bit aborts(input int op, input int cnt, input int abort_step);
        int len;
        len = (op == 0) ? 1 : cnt;
        return (abort_step >= 1 && abort_step <= len);
    endfunction

    // Cycle numbers count from 1 = first cycle after the accept edge.
    task automatic run_cmd(input int op, input int cnt, input int data, input int sin,
                           input int abort_step, input int start,
                           output int active, output int done_cyc, output int abort_cyc,
                           output int ready_cyc, output int done_n, output int abort_n,
                           output int final_q);
        int steps;
        int w;
        int exp_sel;
        steps = steps_of(op, cnt, abort_step);
        exp_sel = (op == 0) ? 3 : (op == 2) ? 2 : 1;
        exp_q.delete();
        for (int s = 1; s <= steps; s++) exp_q.push_back(W'(model(start, op, s, sin, data)));
        active = 0; done_cyc = -1; abort_cyc = -1; ready_cyc = -1; done_n = 0; abort_n = 0;
        w = 0;
        @(negedge clk);
        while (!cmd_if.cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", cmd_if.cmd_ready, 1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'(op);
        cmd_if.cmd_cnt   = CW'(cnt);
        cmd_if.cmd_data  = W'(data);
        cmd_if.cmd_sin   = sin[0];
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                cmd_if.cmd_valid = 1'b0;
                cmd_if.cmd_op    = 2'($urandom);
                cmd_if.cmd_cnt   = CW'($urandom);
                cmd_if.cmd_data  = W'($urandom);
                cmd_if.cmd_sin   = 1'($urandom);
            end
            if (cyc >= 2 && exp_q.size() > 0) check("trace", usr_p_dout, exp_q.pop_front());
            if (usr_sel != SEL_HOLD) begin
                active++;
                check("sel_code", usr_sel, exp_sel);
                if (op == 3) check("rotr_fb", usr_s_right_din, usr_p_dout[0]);
                if (op == 1) check("shr_fill", {usr_s_right_din, usr_s_left_din}, {sin[0], 1'b0});
                if (op == 2) check("shl_fill", {usr_s_right_din, usr_s_left_din}, {1'b0, sin[0]});
            end
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (aborted) begin
                abort_n++;
                if (abort_cyc < 0) abort_cyc = cyc;
            end
            if (cmd_if.cmd_ready) begin
                ready_cyc = cyc;
                break;
            end
            abort = (cyc == abort_step);
        end
        abort = 1'b0;
        check("trace_left", exp_q.size(), 0);
        final_q = int'(usr_p_dout);
    endtask

    task automatic do_cmd(input string tag, input int op, input int cnt, input int data,
                          input int sin, input int abort_step,
                          input int exp_final, input int exp_active,
                          input int exp_done, input int exp_abort);
        int active, done_cyc, abort_cyc, ready_cyc, done_n, abort_n, final_q;
        int end_cyc;
        run_cmd(op, cnt, data, sin, abort_step, model_q,
                active, done_cyc, abort_cyc, ready_cyc, done_n, abort_n, final_q);
        end_cyc = (exp_done > 0) ? exp_done : exp_abort;
        check({tag, "_final"},     final_q,   exp_final);
        check({tag, "_active"},    active,    exp_active);
        check({tag, "_done_cyc"},  done_cyc,  exp_done);
        check({tag, "_abort_cyc"}, abort_cyc, exp_abort);
        check({tag, "_done_n"},    done_n,    (exp_done > 0) ? 1 : 0);
        check({tag, "_abort_n"},   abort_n,   (exp_abort > 0) ? 1 : 0);
        check({tag, "_ready_cyc"}, ready_cyc, end_cyc + 1);
        model_q = exp_final;
    endtask

    typedef struct {
        int op;
        int cnt;
        int data;
        int sin;
        int abort_step;
        int exp_final;
        int exp_active;
        int exp_done;
        int exp_abort;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int op, cnt, data, sin, ab, st;

        vecs[0]  = '{0, 0, 4'b1101, 0, 0, 4'b1101, 1, 2, -1};
        vecs[1]  = '{1, 2, 0,       0, 0, 4'b0011, 2, 3, -1};
        vecs[2]  = '{0, 0, 4'b1101, 0, 0, 4'b1101, 1, 2, -1};
        vecs[3]  = '{2, 3, 0,       1, 0, 4'b1111, 3, 4, -1};
        vecs[4]  = '{0, 5, 4'b1101, 1, 0, 4'b1101, 1, 2, -1};
        vecs[5]  = '{3, 4, 0,       0, 0, 4'b1101, 4, 5, -1};
        vecs[6]  = '{1, 0, 0,       1, 0, 4'b1101, 0, 1, -1};
        vecs[7]  = '{1, 5, 0,       0, 1, 4'b0110, 1, -1, 2};
        vecs[8]  = '{3, 7, 0,       1, 0, 4'b1100, 7, 8, -1};
        vecs[9]  = '{0, 0, 4'b1010, 0, 1, 4'b1010, 1, -1, 2};
        vecs[10] = '{1, 7, 0,       1, 0, 4'b1111, 7, 8, -1};

        rst = 1'b1;
        abort = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op = 2'd0;
        cmd_if.cmd_cnt = '0;
        cmd_if.cmd_data = '0;
        cmd_if.cmd_sin = 1'b0;

        repeat (2) @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        @(negedge clk);
        check("rst_ready",   cmd_if.cmd_ready, 0);
        check("rst_sel",     usr_sel, SEL_HOLD);
        check("rst_p_din",   usr_p_din, 0);
        check("rst_serial",  {usr_s_right_din, usr_s_left_din}, 0);
        check("rst_flags",   {busy, done, aborted}, 0);
        check("rst_state",   dbg_state, ST_IDLE);
        cmd_if.cmd_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", cmd_if.cmd_ready, 1);

        // abort while idle must not start anything
        abort = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_abort", {busy, aborted, done, usr_sel}, 0);
        abort = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].cnt, vecs[i].data, vecs[i].sin,
                   vecs[i].abort_step, vecs[i].exp_final, vecs[i].exp_active,
                   vecs[i].exp_done, vecs[i].exp_abort);
        end

        // reset in the middle of a left shift
        do_cmd("pre_rst_load", 0, 0, 4'b1101, 0, 0, 4'b1101, 1, 2, -1);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op = 2'(OP_SHL);
        cmd_if.cmd_cnt = CW'(5);
        cmd_if.cmd_sin = 1'b1;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        check("mid_shl_sel", usr_sel, SEL_SHL);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_async_sel", usr_sel, SEL_HOLD);
        check("rst_async_busy", busy, 0);
        check("rst_async_ready", cmd_if.cmd_ready, 0);
        @(negedge clk);
        check("rst_no_done", {done, aborted}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_after_ready", cmd_if.cmd_ready, 1);
        check("rst_after_flags", {busy, done, aborted, usr_sel}, 0);
        check("rst_after_usr", usr_p_dout, 0);
        model_q = 0;

        for (int i = 0; i < 40; i++) begin
            op   = int'($urandom_range(0, 3));
            cnt  = int'($urandom_range(0, 7));
            data = int'($urandom_range(0, 15));
            sin  = int'($urandom_range(0, 1));
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
            st   = steps_of(op, cnt, ab);
            if (aborts(op, cnt, ab))
                do_cmd($sformatf("rnd%0d", i), op, cnt, data, sin, ab,
                       model(model_q, op, st, sin, data), st, -1, st + 1);
            else
                do_cmd($sformatf("rnd%0d", i), op, cnt, data, sin, ab,
                       model(model_q, op, st, sin, data), st, st + 1, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
